// File: rtl/keypad_num_entry_if.sv
// Keypad matrix, clear and assembled-number bundle between keypad entry logic and its surroundings.
// Pure wiring, no latency; no backpressure (key_valid is a one-cycle pulse with no ready).
interface keypad_num_entry_if #(
    parameter int NUM_SIZE = 16
);
    logic [3:0]          col;
    logic                clr;
    logic [3:0]          row;
    logic [NUM_SIZE-1:0] num;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    modport master (
        output col, clr,
        input  row, num, key_code, key_valid, key_held
    );

    modport slave (
        input  col, clr,
        output row, num, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_num_entry.sv
// Scans a 4x4 hex keypad, debounces presses/releases and shifts accepted digits into num.
// Latency: 2-cycle col sync + DEBOUNCE_CNT stable cycles + 1 before key_valid; no backpressure.
module keypad_num_entry #(
    parameter int NUM_SIZE     = 16,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_num_entry_if.slave kp
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          sync1_q, col_s;
    logic [3:0]          row_q, row_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DEB_W-1:0]    deb_q, deb_d, deb_inc;
    logic [3:0]          pattern_q, pattern_d;
    logic [NUM_SIZE-1:0] num_q, num_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;
    logic [1:0]          row_idx, col_idx;
    logic [3:0]          code;

    // Lowest-index low bit wins, so several closed columns resolve deterministically.
    always_comb begin
        row_idx = 2'd0;
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_q[i])     row_idx = 2'(i);
            if (!pattern_q[i]) col_idx = 2'(i);
        end
        code = {row_idx, col_idx};
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        div_d       = div_q;
        deb_d       = deb_q;
        pattern_d   = pattern_q;
        num_d       = num_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        deb_inc     = deb_q + DEB_W'(1);

        case (state_q)
            SCAN: begin
                // div_q != 0 gives the freshly driven row one cycle to settle
                if (col_s != 4'hF && div_q != '0) begin
                    pattern_d = col_s;
                    deb_d     = '0;
                    state_d   = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    row_d = {row_q[2:0], row_q[3]};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (col_s != pattern_q) begin
                    div_d   = '0;
                    state_d = SCAN;
                end else begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_DONE) state_d = PRESSED;
                end
            end
            PRESSED: begin
                key_valid_d = 1'b1;
                key_code_d  = code;
                num_d       = NUM_SIZE'({num_q, code});
                key_held_d  = 1'b1;
                deb_d       = '0;
                state_d     = RELEASE;
            end
            RELEASE: begin
                // Row stays frozen here, so a held key can neither repeat nor let another key in
                if (col_s != 4'hF) begin
                    deb_d = '0;
                end else begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        key_held_d = 1'b0;
                        div_d      = '0;
                        state_d    = SCAN;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (kp.clr) num_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 4'hF;
            col_s       <= 4'hF;
            state_q     <= SCAN;
            row_q       <= 4'b1110;
            div_q       <= '0;
            deb_q       <= '0;
            pattern_q   <= 4'hF;
            num_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= kp.col;
            col_s       <= sync1_q;
            state_q     <= state_d;
            row_q       <= row_d;
            div_q       <= div_d;
            deb_q       <= deb_d;
            pattern_q   <= pattern_d;
            num_q       <= num_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.num       = num_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_num_entry.sv
// Keypad entry bench: a keypad matrix model drives col from row, a scoreboard holds expected (code, num) per accepted press.
module tb_keypad_num_entry;
    localparam int NUM_SIZE = 16;
    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 8;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] num;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pressed;
    logic [3:0]  col_v;
    logic [15:0] model_num;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          pulses   = 0;
    int          pushed   = 0;

    always #5 clk = ~clk;

    keypad_num_entry_if #(.NUM_SIZE(NUM_SIZE)) kif ();

    keypad_num_entry #(
        .NUM_SIZE    (NUM_SIZE),
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEB_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif.slave)
    );

    // Matrix model: a closed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !kif.row[r]) col_v[c] = 1'b0;
    end
    assign kif.col = col_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_key(input logic [3:0] code, input bit cleared);
        if (cleared) model_num = 16'h0000;
        else         model_num = {model_num[11:0], code};
        exp_q.push_back('{code: code, num: model_num});
        pushed++;
    endtask

    task automatic pulse_clr();
        kif.clr = 1'b1;
        @(negedge clk);
        kif.clr = 1'b0;
        model_num = 16'h0000;
        check("num_after_clr", 32'(kif.num), 32'h0);
    endtask

    task automatic press_key(input int code, input int hold, input int gap, input bit rnd_clr);
        expect_key(4'(code), 1'b0);
        pressed = 16'h0001 << code;
        repeat (hold) @(negedge clk);
        pressed = 16'h0000;
        repeat (gap / 2) @(negedge clk);
        if (rnd_clr && $urandom_range(0, 3) == 0) pulse_clr();
        repeat (gap - gap / 2) @(negedge clk);
    endtask

    task automatic wait_held_low(input string name);
        int n;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(kif.key_held), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},       32'(kif.row),       32'hE);
        check({tag, "_num"},       32'(kif.num),       32'h0);
        check({tag, "_key_code"},  32'(kif.key_code),  32'h0);
        check({tag, "_key_valid"}, 32'(kif.key_valid), 32'h0);
        check({tag, "_key_held"},  32'(kif.key_held),  32'h0);
    endtask

    // Monitor: every key_valid pulse must match the oldest outstanding expected press.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && kif.key_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_pulse key_code=%h num=%h required=no pulse", kif.key_code, kif.num);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("key_code", 32'(kif.key_code), 32'(mon_e.code));
                    check("num_at_pulse", 32'(kif.num), 32'(mon_e.num));
                    check("key_held_at_pulse", 32'(kif.key_held), 32'h1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] exp_row;
        pressed   = 16'h0000;
        kif.clr   = 1'b0;
        model_num = 16'h0000;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle scan: each row held low for SCAN_DIV cycles, rotating 0,1,2,3
        for (int k = 0; k < 16; k++) begin
            exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check("scan_row", 32'(kif.row), 32'(exp_row));
            @(negedge clk);
        end
        check("idle_num", 32'(kif.num), 32'h0);

        // Single key (1,2): key_held must outlast the release by the debounce time
        expect_key(4'h6, 1'b0);
        pressed = 16'h0040;
        repeat (60) @(negedge clk);
        check("num_after_key6", 32'(kif.num), 32'h0006);
        check("held_while_pressed", 32'(kif.key_held), 32'h1);
        pressed = 16'h0000;
        repeat (4) @(negedge clk);
        check("held_after_release_4", 32'(kif.key_held), 32'h1);
        repeat (16) @(negedge clk);
        check("held_after_release_20", 32'(kif.key_held), 32'h0);
        pulse_clr();

        // Digits 1..5: oldest digit falls off the top
        press_key(1, 60, 30, 1'b0);
        press_key(2, 60, 30, 1'b0);
        press_key(3, 60, 30, 1'b0);
        press_key(4, 60, 30, 1'b0);
        press_key(5, 60, 30, 1'b0);
        check("num_2345", 32'(kif.num), 32'h2345);

        // Clear coinciding with acceptance of key A
        pulse_clr();
        press_key(1, 60, 30, 1'b0);
        press_key(2, 60, 30, 1'b0);
        press_key(3, 60, 30, 1'b0);
        expect_key(4'h4, 1'b0);
        pressed = 16'h0010;
        repeat (60) @(negedge clk);
        check("num_1234", 32'(kif.num), 32'h1234);
        pressed = 16'h0400;
        expect_key(4'hA, 1'b1);
        wait_held_low("release_key4");
        repeat (13) @(negedge clk);
        kif.clr = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kif.key_valid !== 1'b1 && n < 20);
        kif.clr = 1'b0;
        check("clr_pulse_seen", 32'(kif.key_valid), 32'h1);
        check("clr_wins_num", 32'(kif.num), 32'h0);
        pressed = 16'h0000;
        wait_held_low("release_keyA");

        // Reset in the middle of debouncing key (2,1); key still held afterwards
        pressed = 16'h0200;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        model_num = 16'h0000;
        expect_key(4'h9, 1'b0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        pressed = 16'h0000;
        repeat (30) @(negedge clk);

        // Bouncing key (3,3): no acceptance until it holds steady
        for (int i = 0; i < 14; i++) begin
            pressed[15] = ~pressed[15];
            repeat (3) @(negedge clk);
        end
        check("bounce_no_pulse_num", 32'(kif.num), 32'h0009);
        expect_key(4'hF, 1'b0);
        pressed = 16'h8000;
        repeat (60) @(negedge clk);
        pressed = 16'h0000;
        repeat (30) @(negedge clk);

        // Two keys on row 2 together: lowest column wins, no repeat while held
        expect_key(4'h8, 1'b0);
        pressed = 16'h0900;
        repeat (200) @(negedge clk);
        pressed = 16'h0000;
        repeat (30) @(negedge clk);

        for (int i = 0; i < 10; i++)
            press_key($urandom_range(0, 15), $urandom_range(50, 90), $urandom_range(30, 50), 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("pulse_count", 32'(pulses), 32'(pushed));
        check("final_num", 32'(kif.num), 32'(model_num));
        check("final_key_held", 32'(kif.key_held), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_num_entry.md
Name: keypad_num_entry

Overview:
- Input-side counterpart of the seven-segment number display: scans a 4x4 hex matrix keypad, debounces key presses and assembles a NUM_SIZE-bit hex number.
- Each accepted key shifts one hex digit into the number from the right.
- Output `num` feeds the display driver directly, and its width matches the display's `num` port.
- Sits in sys_part beside the display driver, in the board clock domain.

Parameters:
- NUM_SIZE, 16, width of the assembled number; must be a multiple of 4.
- SCAN_DIV, 1000, clk cycles each row is driven during scanning; minimum 2.
- DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- col  input  4  keypad column lines, active-low (pulled up; low = key closed on driven row).
- clr  input  1  synchronous clear of `num`.
- row  output  4  keypad row drive, active-low, exactly one bit low at all times.
- num  output  NUM_SIZE  assembled hex number, newest digit in [3:0].
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse on acceptance.
- key_held  output  1  high while an accepted key has not yet been released.

Behaviour:
- Reset values (async, on rst high): row=4'b1110, num=0, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchronizer flops=4'b1111.
- Synchronizer: col passes through a 2-flop synchronizer (col_s); all decisions use col_s.
  - A pin change is seen 2 cycles later.
- Key map: row r (bit r low), lowest-index low column c → code = 4*r + c.
  - Several columns low at once: the lowest index wins.
- State SCAN:
  - div counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the low bit of row rotates left (1110→1101→1011→0111→1110) and the counter clears.
  - If col_s != 4'b1111 and the counter ≥ 1 (row settled for one cycle): latch col_s as pattern, freeze row, clear the debounce counter, go DEBOUNCE.
- State DEBOUNCE:
  - Each cycle col_s == pattern: counter += 1.
  - col_s != pattern: return to SCAN (row unchanged, div counter cleared, no output).
  - On reaching DEBOUNCE_CNT: go PRESSED.
- State PRESSED (exactly 1 cycle):
  - key_valid=1 and key_code=code.
  - num <= {num[NUM_SIZE-5:0], code}; the oldest digit is discarded (wrap-off).
  - key_held <= 1.
  - Then go RELEASE.
- State RELEASE:
  - Wait for col_s == 4'b1111 for DEBOUNCE_CNT consecutive cycles; any low bit restarts the count.
  - Then key_held <= 0, div counter cleared, go SCAN.
  - Row stays frozen, so a held key produces no repeat and no second key.
- clr:
  - Sets num=0 on the next edge in any state.
  - If clr and the PRESSED cycle coincide, clr wins: num=0, but key_valid/key_code/key_held still update normally.
- Reset mid-operation: everything returns to reset values immediately; a key still held after reset release is detected fresh as a new press.
- key_valid is 0 outside PRESSED.
- key_code holds its value until the next acceptance.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CNT=8; the bench keypad model pulls col[c] low when row[r] is low and key (r,c) is pressed):
- Reset, no keys → row cycles 1110,1101,1011,0111 every 4 clk; num=0000; key_valid never high.
- Press key (1,2) steadily → exactly one key_valid pulse with key_code=4'h6; num=0x0006; key_held high until release +8 stable cycles.
- Press keys 1, 2, 3, 4, 5 in sequence ((0,1),(0,2),(0,3),(1,0),(1,1)) with releases between → num goes 0x0001, 0x0012, 0x0123, 0x1234, 0x2345; the oldest digit drops.
- Bounce: toggle key (3,3) every 3 cycles for 40 cycles, then hold → no pulse during bouncing; a single key_valid with code 4'hF after stable hold.
- Keys (2,0) and (2,3) pressed together → key_code=4'h8; holding for 200 cycles yields no second pulse.
- num=0x1234, assert clr on the PRESSED cycle of key 4'hA → num=0x0000 and key_valid=1 with key_code=4'hA; assert rst mid-DEBOUNCE → all outputs at reset values, row=1110.
